// File: rtl/lcd_stream_pkg.sv
// Shared types and constants for the LCD pixel-stream arbiter.
package lcd_stream_pkg;

  localparam int LCD_DATA_W  = 24;
  localparam int LCD_EMPTY_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [LCD_DATA_W-1:0]  data;
    logic                   sop;
    logic                   eop;
    logic [LCD_EMPTY_W-1:0] empty;
  } lcd_beat_t;

  function automatic logic [1:0] grant_onehot(input arb_state_t s);
    logic [1:0] g;
    g = '0;
    case (s)
      GRANT0:  g = 2'b01;
      GRANT1:  g = 2'b10;
      default: g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/lcd_stream_arbiter_rr_pick.sv
// Combinational two-way round-robin picker: on a tie the source that did not win last time wins.
module lcd_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/lcd_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one Avalon-ST pixel path between two sources,
// with a registered output stage and stray-beat discard accounting.
module lcd_stream_arbiter
  import lcd_stream_pkg::*;
#(
  parameter int DATA_W  = LCD_DATA_W,
  parameter int EMPTY_W = LCD_EMPTY_W,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               in0_ready,
  input  logic               in0_valid,
  input  logic [DATA_W-1:0]  in0_data,
  input  logic               in0_startofpacket,
  input  logic               in0_endofpacket,
  input  logic [EMPTY_W-1:0] in0_empty,
  output logic               in1_ready,
  input  logic               in1_valid,
  input  logic [DATA_W-1:0]  in1_data,
  input  logic               in1_startofpacket,
  input  logic               in1_endofpacket,
  input  logic [EMPTY_W-1:0] in1_empty,
  input  logic [1:0]         src_enable,
  input  logic               status_clear,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_startofpacket,
  output logic               out_endofpacket,
  output logic [EMPTY_W-1:0] out_empty,
  output logic [1:0]         status_grant,
  output logic               status_error,
  output logic [CNT_W-1:0]   status_drop_count
);

  arb_state_t state_q, state_d;
  logic       last_q, last_d;
  logic       first_q, first_d;

  logic [1:0] req, gnt, stray, rdy;
  logic       up, acc, sel;

  logic [DATA_W-1:0]  b_data;
  logic               b_sop, b_eop;
  logic [EMPTY_W-1:0] b_empty;

  logic               ov_q, ov_d;
  logic [DATA_W-1:0]  od_q, od_d;
  logic               osop_q, osop_d, oeop_q, oeop_d;
  logic [EMPTY_W-1:0] oemp_q, oemp_d;
  logic [1:0]         grant_q, grant_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_base;
  logic [CNT_W:0]     cnt_sum;

  lcd_rr_pick u_pick (
    .req  (req),
    .last (last_q),
    .gnt  (gnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    first_d = first_q;
    case (state_q)
      IDLE: begin
        first_d = 1'b1;
        if (gnt[0])      state_d = GRANT0;
        else if (gnt[1]) state_d = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (acc) begin
          first_d = 1'b0;
          if (b_eop) begin
            state_d = IDLE;
            last_d  = sel;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is forced low while reset is held so nothing is discarded or counted during reset.
  always_comb begin
    up    = out_ready || !ov_q;
    rdy   = '0;
    stray = '0;
    req   = '0;
    acc   = 1'b0;
    sel   = 1'b0;
    if (reset_n) begin
      case (state_q)
        IDLE: begin
          stray = {in1_valid & ~in1_startofpacket, in0_valid & ~in0_startofpacket};
          req   = {in1_valid & in1_startofpacket & src_enable[1],
                   in0_valid & in0_startofpacket & src_enable[0]};
          rdy   = stray;
        end
        GRANT0: begin
          rdy[0] = up;
          acc    = in0_valid & up;
        end
        GRANT1: begin
          rdy[1] = up;
          acc    = in1_valid & up;
          sel    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    b_data  = sel ? in1_data          : in0_data;
    b_sop   = sel ? in1_startofpacket : in0_startofpacket;
    b_eop   = sel ? in1_endofpacket   : in0_endofpacket;
    b_empty = sel ? in1_empty         : in0_empty;

    ov_d   = ov_q;
    od_d   = od_q;
    osop_d = osop_q;
    oeop_d = oeop_q;
    oemp_d = oemp_q;
    if (up) begin
      ov_d = acc;
      if (acc) begin
        od_d   = b_data;
        osop_d = b_sop;
        oeop_d = b_eop;
        oemp_d = b_eop ? b_empty : '0;
      end
    end

    // Clear is applied first so drops in the same cycle land on a zeroed counter.
    cnt_base = status_clear ? '0 : cnt_q;
    cnt_sum  = {1'b0, cnt_base} + (CNT_W+1)'(stray[0]) + (CNT_W+1)'(stray[1]);
    cnt_d    = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    err_d    = (status_clear ? 1'b0 : err_q) | (|stray) | (acc & b_sop & ~first_q);
    grant_d  = grant_onehot(state_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ov_q    <= 1'b0;
      od_q    <= '0;
      osop_q  <= 1'b0;
      oeop_q  <= 1'b0;
      oemp_q  <= '0;
      grant_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ov_q    <= ov_d;
      od_q    <= od_d;
      osop_q  <= osop_d;
      oeop_q  <= oeop_d;
      oemp_q  <= oemp_d;
      grant_q <= grant_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in0_ready         = rdy[0];
  assign in1_ready         = rdy[1];
  assign out_valid         = ov_q;
  assign out_data          = od_q;
  assign out_startofpacket = osop_q;
  assign out_endofpacket   = oeop_q;
  assign out_empty         = oemp_q;
  assign status_grant      = grant_q;
  assign status_error      = err_q;
  assign status_drop_count = cnt_q;

endmodule
